// File: rtl/resize_if.sv
// Command, source-read and destination-write signals of the resize sequencer.
// The master side is the sequencer. The slave side is the host plus the two pixel memories.
interface resize_if #(
  parameter int SRC_AW = 4,
  parameter int DST_AW = 10
);
  logic              start;
  logic              zoom_in;
  logic              zoom_out;
  logic [1:0]        scale;
  logic              src_rd_en;
  logic [SRC_AW-1:0] src_addr;
  logic [7:0]        pixel_in;
  logic              dst_we;
  logic [DST_AW-1:0] dst_addr;
  logic [7:0]        pixel_out;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    input  start, zoom_in, zoom_out, scale, pixel_in, out_ready,
    output src_rd_en, src_addr, dst_we, dst_addr, pixel_out, busy, done, error
  );

  modport slave (
    output start, zoom_in, zoom_out, scale, pixel_in, out_ready,
    input  src_rd_en, src_addr, dst_we, dst_addr, pixel_out, busy, done, error
  );
endinterface

// File: rtl/resize_controller.sv
// Nearest-neighbour resize sequencer: for every output pixel it reads the source pixel,
// captures it, and writes it to the destination. The walk is row-major over the output image.
module resize_controller #(
  parameter int img_height = 4,
  parameter int img_width  = 4,
  parameter int max_scale  = 8
) (
  input  logic     clk,
  input  logic     reset,
  resize_if.master rif
);
  localparam int SRC_N  = img_height * img_width;
  localparam int SRC_AW = (SRC_N > 1) ? $clog2(SRC_N) : 1;
  localparam int DST_N  = max_scale * max_scale * SRC_N;
  localparam int DST_AW = (DST_N > 1) ? $clog2(DST_N) : 1;
  localparam int RW     = $clog2(img_height * max_scale + 1);
  localparam int CW     = $clog2(img_width * max_scale + 1);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;

  state_t            state;
  // Accepted commands always have zoom_out == !zoom_in, so a single direction bit is enough.
  logic              zin;
  logic [1:0]        sc;
  logic [RW-1:0]     r;
  logic [CW-1:0]     c;
  logic [SRC_AW-1:0] src_addr;
  logic [DST_AW-1:0] dst_addr;
  logic [7:0]        pix;
  logic              rd_en, busy, done, err;

  logic [31:0] out_h, out_w, r_ext, c_ext, nr, nc, src_lin;
  logic        col_wrap, last, cmd_bad;

  always_comb begin
    out_h    = zin ? (32'(img_height) << sc) : (32'(img_height) >> sc);
    out_w    = zin ? (32'(img_width)  << sc) : (32'(img_width)  >> sc);
    r_ext    = 32'(r);
    c_ext    = 32'(c);
    col_wrap = (c_ext == out_w - 32'd1);
    last     = col_wrap && (r_ext == out_h - 32'd1);
    nc       = col_wrap ? 32'd0 : c_ext + 32'd1;
    nr       = col_wrap ? r_ext + 32'd1 : r_ext;
    // The source address is computed for the next output pixel, so it is ready when READ begins.
    src_lin  = zin ? ((nr >> sc) * 32'(img_width) + (nc >> sc))
                   : ((nr << sc) * 32'(img_width) + (nc << sc));
    cmd_bad  = (rif.zoom_in == rif.zoom_out) ||
               ((32'd1 << rif.scale) > 32'(max_scale)) ||
               (rif.zoom_out && (((32'(img_height) >> rif.scale) == 32'd0) ||
                                 ((32'(img_width)  >> rif.scale) == 32'd0)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      zin      <= 1'b0;
      sc       <= '0;
      r        <= '0;
      c        <= '0;
      src_addr <= '0;
      dst_addr <= '0;
      pix      <= '0;
      rd_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      unique case (state)
        IDLE: if (rif.start) begin
          if (cmd_bad) begin
            err <= 1'b1;
          end else begin
            zin      <= rif.zoom_in;
            sc       <= rif.scale;
            r        <= '0;
            c        <= '0;
            src_addr <= '0;
            dst_addr <= '0;
            rd_en    <= 1'b1;
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ: state <= CAPTURE;
        CAPTURE: begin
          pix   <= rif.pixel_in;
          state <= WRITE;
        end
        WRITE: if (rif.out_ready) begin
          if (last) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            r        <= RW'(nr);
            c        <= CW'(nc);
            dst_addr <= dst_addr + DST_AW'(1);
            src_addr <= SRC_AW'(src_lin);
            rd_en    <= 1'b1;
            state    <= READ;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The write strobe follows out_ready combinationally, so a stalled write costs no extra cycle.
  assign rif.dst_we    = (state == WRITE) && rif.out_ready;
  assign rif.src_rd_en = rd_en;
  assign rif.src_addr  = src_addr;
  assign rif.dst_addr  = dst_addr;
  assign rif.pixel_out = pix;
  assign rif.busy      = busy;
  assign rif.done      = done;
  assign rif.error     = err;
endmodule

// File: tb/tb_resize_controller.sv
// Self-checking bench for resize_controller. A source memory model and a write monitor
// are compared against a reference model that computes the output image from the zoom rules.
`timescale 1ns/1ps
module tb_resize_controller;
  localparam int H = 4, W = 4, MS = 8;
  localparam int SRC_AW = 4, DST_AW = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  resize_if #(.SRC_AW(SRC_AW), .DST_AW(DST_AW)) rif();
  resize_controller #(.img_height(H), .img_width(W), .max_scale(MS))
    dut (.clk(clk), .reset(reset), .rif(rif));

  int checks = 0, failures = 0;
  int cyc = 0, base = 0;
  logic [7:0] src_mem [H*W];
  int rd_q[$], wa_q[$], wd_q[$], wc_q[$];
  int done_cnt, done_rel, err_cnt, err_rel, busy_after_done;
  bit busy_seen, prev_done;
  int exp_src[$];

  // Synchronous source RAM: data appears the cycle after the read strobe.
  always @(posedge clk) if (rif.src_rd_en) rif.pixel_in <= src_mem[rif.src_addr];
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records accesses and pulses, with cycle numbers relative to command acceptance.
  always @(negedge clk) begin
    int rel;
    rel = cyc - base + 1;
    if (rif.src_rd_en) rd_q.push_back(int'(rif.src_addr));
    if (rif.dst_we) begin
      wa_q.push_back(int'(rif.dst_addr));
      wd_q.push_back(int'(rif.pixel_out));
      wc_q.push_back(rel);
    end
    if (rif.done) begin done_cnt++; done_rel = rel; end
    if (rif.error) begin err_cnt++; err_rel = rel; end
    if (rif.busy) busy_seen = 1'b1;
    if (prev_done) busy_after_done = int'(rif.busy);
    prev_done = rif.done;
  end

  function automatic bit legal(input bit zi, input bit zo, input int sc);
    int f;
    f = 1 << sc;
    if (zi == zo) return 1'b0;
    if (f > MS) return 1'b0;
    if (zo && ((H / f) == 0 || (W / f) == 0)) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: list of source indices, one per output pixel in row-major order.
  task automatic build_model(input bit zi, input int sc);
    int f, oh, ow;
    f  = 1 << sc;
    oh = zi ? H * f : H / f;
    ow = zi ? W * f : W / f;
    exp_src.delete();
    for (int r = 0; r < oh; r++)
      for (int c = 0; c < ow; c++)
        exp_src.push_back(zi ? (r / f) * W + (c / f) : (r * f) * W + (c * f));
  endtask

  task automatic fill_mem(input bit ramp);
    for (int i = 0; i < H*W; i++) src_mem[i] = ramp ? 8'(i) : 8'($urandom);
  endtask

  task automatic issue(input bit zi, input bit zo, input int sc);
    @(negedge clk);
    rd_q.delete(); wa_q.delete(); wd_q.delete(); wc_q.delete();
    done_cnt = 0; done_rel = -1; err_cnt = 0; err_rel = -1;
    busy_after_done = -1; busy_seen = 1'b0;
    rif.start = 1'b1; rif.zoom_in = zi; rif.zoom_out = zo; rif.scale = 2'(sc);
    base = cyc + 1;
    @(negedge clk);
    rif.start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done_cnt > 0) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({rif.src_rd_en, rif.dst_we, rif.busy, rif.done, rif.error, rif.src_addr,
         rif.dst_addr, rif.pixel_out} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rd=%b we=%b busy=%b done=%b err=%b sa=%0d da=%0d px=%0d want all 0",
               rif.src_rd_en, rif.dst_we, rif.busy, rif.done, rif.error, rif.src_addr,
               rif.dst_addr, rif.pixel_out);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_copy();
    bit ok;
    fill_mem(1'b1);
    issue(1'b1, 1'b0, 0);
    wait_done(100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL copy_timeout got no done want done"); end
    checks++;
    if (wa_q.size() !== 16) begin failures++; $display("FAIL copy_count got %0d want 16", wa_q.size()); end
    for (int i = 0; i < wa_q.size() && i < 16; i++) begin
      checks++;
      if (wa_q[i] !== i || wd_q[i] !== i) begin
        failures++;
        $display("FAIL copy_write[%0d] got addr=%0d data=%0d want addr=%0d data=%0d", i, wa_q[i], wd_q[i], i, i);
      end
    end
    checks++;
    if (wc_q.size() > 0 && wc_q[0] !== 3) begin failures++; $display("FAIL copy_first_we got cycle %0d want 3", wc_q[0]); end
    checks++;
    if (done_rel !== 49 || done_cnt !== 1) begin
      failures++; $display("FAIL copy_done got cycle=%0d count=%0d want cycle=49 count=1", done_rel, done_cnt);
    end
    checks++;
    if (busy_after_done !== 0) begin failures++; $display("FAIL copy_busy_fall got %0d want 0", busy_after_done); end
  endtask

  task automatic test_zoom_in_2x();
    bit ok;
    fill_mem(1'b0);
    build_model(1'b1, 1);
    issue(1'b1, 1'b0, 1);
    wait_done(300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL zin2_timeout got no done want done"); end
    checks++;
    if (wa_q.size() !== 64 || rd_q.size() !== 64) begin
      failures++; $display("FAIL zin2_count got writes=%0d reads=%0d want 64", wa_q.size(), rd_q.size());
    end
    for (int i = 0; i < wa_q.size() && i < 64 && i < rd_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== i || rd_q[i] !== exp_src[i] || wd_q[i] !== int'(src_mem[exp_src[i]])) begin
        failures++;
        $display("FAIL zin2_pixel[%0d] got addr=%0d src=%0d data=%0d want addr=%0d src=%0d data=%0d",
                 i, wa_q[i], rd_q[i], wd_q[i], i, exp_src[i], src_mem[exp_src[i]]);
      end
    end
    checks++;
    if (done_rel !== 193) begin failures++; $display("FAIL zin2_done got cycle %0d want 193", done_rel); end
  endtask

  task automatic test_zoom_out_2x();
    bit ok;
    fill_mem(1'b0);
    build_model(1'b0, 1);
    issue(1'b0, 1'b1, 1);
    wait_done(40, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL zout2_timeout got no done want done"); end
    checks++;
    if (wa_q.size() !== 4 || rd_q.size() !== 4) begin
      failures++; $display("FAIL zout2_count got writes=%0d reads=%0d want 4", wa_q.size(), rd_q.size());
    end
    for (int i = 0; i < 4 && i < wa_q.size() && i < rd_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== i || rd_q[i] !== exp_src[i] || wd_q[i] !== int'(src_mem[exp_src[i]])) begin
        failures++;
        $display("FAIL zout2_pixel[%0d] got addr=%0d src=%0d data=%0d want addr=%0d src=%0d data=%0d",
                 i, wa_q[i], rd_q[i], wd_q[i], i, exp_src[i], src_mem[exp_src[i]]);
      end
    end
    checks++;
    if (done_rel !== 13) begin failures++; $display("FAIL zout2_done got cycle %0d want 13", done_rel); end
  endtask

  task automatic test_illegal();
    bit zi [3] = '{1'b0, 1'b1, 1'b0};
    bit zo [3] = '{1'b1, 1'b1, 1'b0};
    int sc [3] = '{3, 0, 1};
    for (int k = 0; k < 3; k++) begin
      issue(zi[k], zo[k], sc[k]);
      repeat (4) @(negedge clk);
      checks++;
      if (err_cnt !== 1 || err_rel !== 1) begin
        failures++; $display("FAIL illegal%0d_error got count=%0d cycle=%0d want count=1 cycle=1", k, err_cnt, err_rel);
      end
      checks++;
      if (busy_seen || rd_q.size() != 0 || wa_q.size() != 0 || done_cnt != 0) begin
        failures++;
        $display("FAIL illegal%0d_quiet got busy=%b reads=%0d writes=%0d done=%0d want 0 0 0 0",
                 k, busy_seen, rd_q.size(), wa_q.size(), done_cnt);
      end
    end
  endtask

  task automatic test_random();
    bit zi, zo, ok;
    int sc, n;
    for (int t = 0; t < 8; t++) begin
      zi = 1'($urandom_range(1, 0));
      zo = 1'($urandom_range(1, 0));
      sc = int'($urandom_range(3, 0));
      fill_mem(1'b0);
      issue(zi, zo, sc);
      if (legal(zi, zo, sc)) begin
        build_model(zi, sc);
        n = exp_src.size();
        wait_done(3 * n + 20, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rand%0d_timeout zi=%b sc=%0d got no done want done", t, zi, sc); end
        checks++;
        if (wa_q.size() !== n || rd_q.size() !== n) begin
          failures++; $display("FAIL rand%0d_count got writes=%0d reads=%0d want %0d", t, wa_q.size(), rd_q.size(), n);
        end
        for (int i = 0; i < n && i < wa_q.size() && i < rd_q.size(); i++) begin
          checks++;
          if (wa_q[i] !== i || rd_q[i] !== exp_src[i] || wd_q[i] !== int'(src_mem[exp_src[i]]) ||
              wc_q[i] !== 3 * (i + 1)) begin
            failures++;
            $display("FAIL rand%0d_pixel[%0d] got addr=%0d src=%0d data=%0d cyc=%0d want %0d %0d %0d %0d",
                     t, i, wa_q[i], rd_q[i], wd_q[i], wc_q[i], i, exp_src[i], src_mem[exp_src[i]], 3 * (i + 1));
          end
        end
        checks++;
        if (done_rel !== 3 * n + 1 || busy_after_done !== 0) begin
          failures++;
          $display("FAIL rand%0d_done got cycle=%0d busy_after=%0d want cycle=%0d busy_after=0",
                   t, done_rel, busy_after_done, 3 * n + 1);
        end
      end else begin
        repeat (4) @(negedge clk);
        checks++;
        if (err_cnt !== 1 || busy_seen || wa_q.size() != 0 || rd_q.size() != 0) begin
          failures++;
          $display("FAIL rand%0d_reject zi=%b zo=%b sc=%0d got err=%0d busy=%b wr=%0d rd=%0d want 1 0 0 0",
                   t, zi, zo, sc, err_cnt, busy_seen, wa_q.size(), rd_q.size());
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    fill_mem(1'b0);
    issue(1'b1, 1'b0, 0);
    while (cyc - base + 1 < 9) begin @(posedge clk); #1; end
    rif.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (rif.dst_we !== 1'b0 || rif.dst_addr !== DST_AW'(2) || rif.pixel_out !== src_mem[2]) begin
        failures++;
        $display("FAIL bp_hold[%0d] got we=%b addr=%0d data=%0d want we=0 addr=2 data=%0d",
                 k, rif.dst_we, rif.dst_addr, rif.pixel_out, src_mem[2]);
      end
    end
    @(posedge clk); #1;
    rif.out_ready = 1'b1;
    wait_done(100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_timeout got no done want done"); end
    checks++;
    if (wa_q.size() !== 16 || (wa_q.size() > 3 && (wc_q[2] !== 14 || wc_q[3] !== 17))) begin
      failures++; $display("FAIL bp_timing got writes=%0d third_cycle=%0d want 16 writes, third at 14",
                           wa_q.size(), (wc_q.size() > 2) ? wc_q[2] : -1);
    end
    for (int i = 0; i < 16 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== i || wd_q[i] !== int'(src_mem[i])) begin
        failures++; $display("FAIL bp_write[%0d] got addr=%0d data=%0d want addr=%0d data=%0d",
                             i, wa_q[i], wd_q[i], i, src_mem[i]);
      end
    end
    checks++;
    if (done_rel !== 54) begin failures++; $display("FAIL bp_done got cycle %0d want 54", done_rel); end
  endtask

  task automatic test_abort();
    bit ok;
    int guard;
    fill_mem(1'b0);
    issue(1'b1, 1'b0, 1);
    guard = 0;
    while (wa_q.size() < 20 && guard < 200) begin @(negedge clk); guard++; end
    checks++;
    if (wa_q.size() < 20) begin failures++; $display("FAIL abort_reach got writes=%0d want 20", wa_q.size()); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({rif.src_rd_en, rif.dst_we, rif.busy, rif.done, rif.error, rif.src_addr,
         rif.dst_addr, rif.pixel_out} !== '0) begin
      failures++;
      $display("FAIL abort_outputs got busy=%b sa=%0d da=%0d px=%0d want all 0",
               rif.busy, rif.src_addr, rif.dst_addr, rif.pixel_out);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    checks++;
    if (done_cnt !== 0) begin failures++; $display("FAIL abort_no_done got %0d want 0", done_cnt); end
    fill_mem(1'b0);
    build_model(1'b0, 1);
    issue(1'b0, 1'b1, 1);
    repeat (2) @(negedge clk);
    rif.start = 1'b1; rif.zoom_in = 1'b1; rif.zoom_out = 1'b0; rif.scale = 2'd1;
    @(negedge clk);
    rif.start = 1'b0;
    wait_done(40, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL abort_next_timeout got no done want done"); end
    checks++;
    if (wa_q.size() !== 4 || done_rel !== 13 || err_cnt !== 0) begin
      failures++; $display("FAIL abort_next_shape got writes=%0d done=%0d err=%0d want 4 13 0",
                           wa_q.size(), done_rel, err_cnt);
    end
    for (int i = 0; i < 4 && i < wa_q.size() && i < rd_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== i || rd_q[i] !== exp_src[i] || wd_q[i] !== int'(src_mem[exp_src[i]])) begin
        failures++; $display("FAIL abort_next_pixel[%0d] got addr=%0d src=%0d data=%0d want %0d %0d %0d",
                             i, wa_q[i], rd_q[i], wd_q[i], i, exp_src[i], src_mem[exp_src[i]]);
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (rif.busy !== 1'b0 || done_cnt !== 1) begin
      failures++; $display("FAIL abort_ignored_start got busy=%b done_count=%0d want 0 1", rif.busy, done_cnt);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got no finish want finish within 90000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    rif.start = 1'b0; rif.zoom_in = 1'b0; rif.zoom_out = 1'b0; rif.scale = 2'd0;
    rif.out_ready = 1'b1;
    test_reset();
    test_copy();
    test_zoom_in_2x();
    test_zoom_out_2x();
    test_illegal();
    test_backpressure();
    test_random();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
